adpll_loop_ctrl: RTL and testbench

ADPLL_LOOP_CTRL -- requirements
Module: adpll_loop_ctrl

---
 rtl/adpll_loop_ctrl_if.sv | 24 ++
 rtl/adpll_loop_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_adpll_loop_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/adpll_loop_ctrl_if.sv
// Signal bundle between the ADPLL loop controller, its phase detector and the DCO.
// The slave modport is the controller's view; master is the environment's view.
interface adpll_loop_ctrl_if #(
  parameter int FCW_W = 16
);
  logic             enable_i;
  logic             sample_i;
  logic             pd_out_i;
  logic             pd_enable_o;
  logic [FCW_W-1:0] fcw_o;
  logic             fcw_valid_o;
  logic [2:0]       state_o;
  logic             lock_o;

  modport slave (
    input  enable_i, sample_i, pd_out_i,
    output pd_enable_o, fcw_o, fcw_valid_o, state_o, lock_o
  );

  modport master (
    output enable_i, sample_i, pd_out_i,
    input  pd_enable_o, fcw_o, fcw_valid_o, state_o, lock_o
  );
endinterface

// File: rtl/adpll_loop_ctrl.sv
// Bang-bang ADPLL loop controller: settle, coarse acquisition, fine tracking and
// optional lock detection (enabled by defining ADPLL_LOCK_DETECT_EN).
module adpll_loop_ctrl #(
  parameter int          FCW_W          = 16,
  parameter int unsigned FCW_INIT       = 32'h8000,
  parameter int          COARSE_STEP    = 64,
  parameter int          FINE_STEP      = 1,
  parameter int          SETTLE_SAMPLES = 8,
  parameter int          ACQ_TOGGLES    = 4,
  parameter int          LOCK_COUNT     = 32,
  parameter int          UNLOCK_RUN     = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  adpll_loop_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_TRACK   = 3'd3
`ifdef ADPLL_LOCK_DETECT_EN
    , ST_LOCKED = 3'd4
`endif
  } state_t;

  // One counter is shared by all states; it is cleared on every state change.
  localparam int MAX_A   = (SETTLE_SAMPLES > ACQ_TOGGLES) ? SETTLE_SAMPLES : ACQ_TOGGLES;
  localparam int MAX_B   = (LOCK_COUNT > UNLOCK_RUN) ? LOCK_COUNT : UNLOCK_RUN;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  function automatic logic [FCW_W-1:0] sat_step(input logic [FCW_W-1:0] v,
                                                input logic up,
                                                input logic [FCW_W-1:0] step);
    logic [FCW_W:0] s;
    if (up) begin
      s = {1'b0, v} + {1'b0, step};
      sat_step = s[FCW_W] ? '1 : s[FCW_W-1:0];
    end else begin
      s = {1'b0, v} - {1'b0, step};
      sat_step = s[FCW_W] ? '0 : s[FCW_W-1:0];
    end
  endfunction

  state_t           r_state;
  logic [FCW_W-1:0] r_fcw;
  logic             r_fcw_valid;
  logic             r_pd_enable;
  logic             r_prev;
  logic             r_prev_vld;
  logic [CNT_W-1:0] r_cnt;

  logic             w_differ;
  logic [FCW_W-1:0] w_fcw_coarse;
  logic [FCW_W-1:0] w_fcw_fine;

  assign w_differ     = r_prev_vld && (bus.pd_out_i != r_prev);
  assign w_fcw_coarse = sat_step(r_fcw, bus.pd_out_i, FCW_W'(COARSE_STEP));
  assign w_fcw_fine   = sat_step(r_fcw, bus.pd_out_i, FCW_W'(FINE_STEP));

`ifdef ADPLL_LOCK_DETECT_EN
  logic r_lock;
  assign bus.lock_o = r_lock;
`else
  assign bus.lock_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_fcw       <= FCW_W'(FCW_INIT);
      r_fcw_valid <= 1'b0;
      r_pd_enable <= 1'b0;
      r_prev      <= 1'b0;
      r_prev_vld  <= 1'b0;
      r_cnt       <= '0;
`ifdef ADPLL_LOCK_DETECT_EN
      r_lock      <= 1'b0;
`endif
    end else begin
      r_fcw_valid <= 1'b0;
      if (!bus.enable_i) begin
        // Dropping enable wins over any coincident strobe; fcw is held for resume.
        r_state     <= ST_IDLE;
        r_pd_enable <= 1'b0;
        r_cnt       <= '0;
`ifdef ADPLL_LOCK_DETECT_EN
        r_lock      <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state     <= ST_SETTLE;
            r_pd_enable <= 1'b1;
            r_cnt       <= '0;
          end
          ST_SETTLE: begin
            if (bus.sample_i) begin
              if (r_cnt == CNT_W'(SETTLE_SAMPLES - 1)) begin
                r_state    <= ST_ACQUIRE;
                r_cnt      <= '0;
                r_prev_vld <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          ST_ACQUIRE: begin
            if (bus.sample_i) begin
              r_fcw       <= w_fcw_coarse;
              r_fcw_valid <= 1'b1;
              r_prev      <= bus.pd_out_i;
              r_prev_vld  <= 1'b1;
              if (w_differ) begin
                if (r_cnt == CNT_W'(ACQ_TOGGLES - 1)) begin
                  r_state <= ST_TRACK;
                  r_cnt   <= '0;
                end else begin
                  r_cnt <= r_cnt + 1'b1;
                end
              end
            end
          end
          ST_TRACK: begin
            if (bus.sample_i) begin
              r_fcw       <= w_fcw_fine;
              r_fcw_valid <= 1'b1;
              r_prev      <= bus.pd_out_i;
              r_prev_vld  <= 1'b1;
`ifdef ADPLL_LOCK_DETECT_EN
              if (!w_differ) begin
                r_cnt <= '0;
              end else if (r_cnt == CNT_W'(LOCK_COUNT - 1)) begin
                r_state <= ST_LOCKED;
                r_lock  <= 1'b1;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
`endif
            end
          end
`ifdef ADPLL_LOCK_DETECT_EN
          ST_LOCKED: begin
            if (bus.sample_i) begin
              r_fcw       <= w_fcw_fine;
              r_fcw_valid <= 1'b1;
              r_prev      <= bus.pd_out_i;
              r_prev_vld  <= 1'b1;
              // r_cnt holds the current same-polarity run length; a flip starts a run of 1.
              if (w_differ) begin
                r_cnt <= CNT_W'(1);
              end else if (r_cnt == CNT_W'(UNLOCK_RUN - 1)) begin
                r_state <= ST_TRACK;
                r_lock  <= 1'b0;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
`endif
          default: begin
            r_state     <= ST_IDLE;
            r_pd_enable <= 1'b0;
            r_cnt       <= '0;
          end
        endcase
      end
    end
  end

  assign bus.pd_enable_o = r_pd_enable;
  assign bus.fcw_o       = r_fcw;
  assign bus.fcw_valid_o = r_fcw_valid;
  assign bus.state_o     = r_state;

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Directed bench for adpll_loop_ctrl; lock checks follow ADPLL_LOCK_DETECT_EN.
module tb_adpll_loop_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  adpll_loop_ctrl_if #(.FCW_W(16)) bus ();

  adpll_loop_ctrl dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe driven at a falling edge; returns at the next falling edge,
  // where the registered update of that strobe is visible.
  task automatic strobe(input logic pd);
    @(negedge clk);
    bus.sample_i = 1'b1;
    bus.pd_out_i = pd;
    @(negedge clk);
    bus.sample_i = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 8; i++) begin
      strobe(1'b1);
      chk("settle_valid", bus.fcw_valid_o, 1'b0);
    end
    chk("settle_done_state", bus.state_o, 3'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       pat [6];
    logic [15:0] exp_fcw [6];
    logic [15:0] held;
    pat     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_fcw = '{16'h8040, 16'h8080, 16'h8040, 16'h8080, 16'h8040, 16'h8080};

    rst = 1'b1;
    bus.enable_i = 1'b0;
    bus.sample_i = 1'b0;
    bus.pd_out_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", bus.state_o, 3'd0);
    chk("rst_fcw", bus.fcw_o, 16'h8000);
    chk("rst_valid", bus.fcw_valid_o, 1'b0);
    chk("rst_pden", bus.pd_enable_o, 1'b0);
    chk("rst_lock", bus.lock_o, 1'b0);
    rst = 1'b0;

    // strobe while idle does nothing
    strobe(1'b1);
    chk("idle_fcw", bus.fcw_o, 16'h8000);
    chk("idle_valid", bus.fcw_valid_o, 1'b0);
    chk("idle_state", bus.state_o, 3'd0);

    bus.enable_i = 1'b1;
    @(negedge clk);
    chk("en_state", bus.state_o, 3'd1);
    chk("en_pden", bus.pd_enable_o, 1'b1);
    for (int i = 0; i < 8; i++) begin
      strobe(1'b1);
      chk("settle_valid", bus.fcw_valid_o, 1'b0);
      chk("settle_fcw", bus.fcw_o, 16'h8000);
      chk("settle_state", bus.state_o, (i < 7) ? 3'd1 : 3'd2);
    end

    // coarse acquisition pattern
    for (int i = 0; i < 6; i++) begin
      strobe(pat[i]);
      chk("acq_fcw", bus.fcw_o, exp_fcw[i]);
      chk("acq_valid", bus.fcw_valid_o, 1'b1);
      chk("acq_state", bus.state_o, (i == 5) ? 3'd3 : 3'd2);
    end
    @(negedge clk);
    chk("acq_valid_drop", bus.fcw_valid_o, 1'b0);

    // 32 alternating samples, starting opposite to the last acquisition sample
    for (int i = 0; i < 32; i++) begin
      strobe((i % 2) == 1);
      chk("trk_fcw", bus.fcw_o, ((i % 2) == 0) ? 16'h807F : 16'h8080);
      if (i == 30) chk("trk_state_pre", bus.state_o, 3'd3);
    end
`ifdef ADPLL_LOCK_DETECT_EN
    chk("lock_state", bus.state_o, 3'd4);
    chk("lock_o", bus.lock_o, 1'b1);
`else
    chk("nolock_state", bus.state_o, 3'd3);
    chk("nolock_o", bus.lock_o, 1'b0);
`endif
    for (int i = 0; i < 4; i++) begin
      strobe(1'b0);
      chk("run_fcw", bus.fcw_o, 16'h807F - 16'(i));
`ifdef ADPLL_LOCK_DETECT_EN
      chk("run_state", bus.state_o, (i < 3) ? 3'd4 : 3'd3);
      chk("run_lock", bus.lock_o, (i < 3) ? 1'b1 : 1'b0);
`else
      chk("run_state", bus.state_o, 3'd3);
      chk("run_lock", bus.lock_o, 1'b0);
`endif
    end

    // disable / re-enable, then enable drop coincident with a sample in ACQUIRE
    @(negedge clk);
    bus.enable_i = 1'b0;
    @(negedge clk);
    chk("dis_state", bus.state_o, 3'd0);
    chk("dis_pden", bus.pd_enable_o, 1'b0);
    bus.enable_i = 1'b1;
    @(negedge clk);
    chk("reen_state", bus.state_o, 3'd1);
    settle();
    held = 16'h807C;
    chk("acq2_fcw", bus.fcw_o, held);
    @(negedge clk);
    bus.enable_i = 1'b0;
    bus.sample_i = 1'b1;
    bus.pd_out_i = 1'b1;
    @(negedge clk);
    bus.sample_i = 1'b0;
    chk("coinc_state", bus.state_o, 3'd0);
    chk("coinc_pden", bus.pd_enable_o, 1'b0);
    chk("coinc_fcw", bus.fcw_o, held);
    chk("coinc_valid", bus.fcw_valid_o, 1'b0);
    bus.enable_i = 1'b1;
    @(negedge clk);
    chk("resume_state", bus.state_o, 3'd1);
    settle();
    chk("resume_held", bus.fcw_o, held);
    strobe(1'b1);
    chk("resume_fcw", bus.fcw_o, 16'h80BC);

    // four toggles into TRACK, one fine step, then asynchronous reset mid-cycle
    strobe(1'b0);
    chk("t_fcw0", bus.fcw_o, 16'h807C);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    chk("t_fcw3", bus.fcw_o, 16'h80BC);
    chk("t_state", bus.state_o, 3'd3);
    strobe(1'b1);
    chk("t_fine", bus.fcw_o, 16'h80BD);
    chk("t_valid", bus.fcw_valid_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", bus.state_o, 3'd0);
    chk("arst_fcw", bus.fcw_o, 16'h8000);
    chk("arst_valid", bus.fcw_valid_o, 1'b0);
    chk("arst_pden", bus.pd_enable_o, 1'b0);
    chk("arst_lock", bus.lock_o, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_state", bus.state_o, 3'd1);

    // upper saturation: settle, then drive the word up with coarse steps
    settle();
    chk("post_rst_fcw", bus.fcw_o, 16'h8000);
    for (int i = 0; i < 520; i++) strobe(1'b1);
    chk("sat_hi_acq", bus.fcw_o, 16'hFFFF);
    chk("sat_hi_acq_state", bus.state_o, 3'd2);
    strobe(1'b0);
    chk("sat_t0", bus.fcw_o, 16'hFFBF);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    chk("sat_t3", bus.fcw_o, 16'hFFFF);
    chk("sat_trk_state", bus.state_o, 3'd3);
    strobe(1'b1);
    chk("sat_hi_fcw", bus.fcw_o, 16'hFFFF);
    chk("sat_hi_valid", bus.fcw_valid_o, 1'b1);
    @(negedge clk);
    chk("sat_hi_valid_once", bus.fcw_valid_o, 1'b0);

    // lower saturation via a fresh acquisition
    bus.enable_i = 1'b0;
    @(negedge clk);
    bus.enable_i = 1'b1;
    @(negedge clk);
    settle();
    for (int i = 0; i < 1030; i++) strobe(1'b0);
    chk("sat_lo_fcw", bus.fcw_o, 16'h0000);
    chk("sat_lo_valid", bus.fcw_valid_o, 1'b1);
    chk("sat_lo_state", bus.state_o, 3'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
